// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one single-port RAM between the
//            instruction-fetch and data load/store request streams, with a
//            busy-wait timeout that flags a bus error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemRen,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [DATA_W-1:0] imemload,
  output logic              i_ready,
  input  logic              dmmRen,
  input  logic              dmmWen,
  input  logic [ADDR_W-1:0] dmmaddr,
  input  logic [DATA_W-1:0] dmmstore,
  output logic [DATA_W-1:0] dmmload,
  output logic              d_ready,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_busy,
  output logic              bus_err
);

  localparam logic [7:0] C_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IACC = 2'd1,
    S_DACC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_data;  // 1 when the most recent grant went to the data side
  logic        r_side_data;
  logic        r_is_wr;
  logic        r_err;
  logic [7:0]  r_wait_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_imemload;
  logic [DATA_W-1:0] r_dmmload;

  logic w_dreq;
  logic w_grant_i;
  logic w_grant_d;
  logic w_finish;
  logic w_abort;
  logic w_in_acc;

  assign w_dreq   = dmmRen | dmmWen;
  assign w_in_acc = (r_state == S_IACC) || (r_state == S_DACC);

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dreq && imemRen) begin
          w_grant_i = r_last_data;
          w_grant_d = ~r_last_data;
        end else begin
          w_grant_i = imemRen;
          w_grant_d = w_dreq;
        end
        if (w_grant_i) w_state_next = S_IACC;
        if (w_grant_d) w_state_next = S_DACC;
      end
      S_IACC, S_DACC: begin
        if (!ram_busy) begin
          w_finish     = 1'b1;
          w_state_next = S_DONE;
        end else if (r_wait_cnt + 8'd1 == C_MAX_WAIT) begin
          w_abort      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_last_data <= 1'b1;
      r_side_data <= 1'b0;
      r_is_wr     <= 1'b0;
      r_err       <= 1'b0;
      r_wait_cnt  <= 8'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_imemload  <= '0;
      r_dmmload   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_i) begin
        r_addr      <= imemaddr;
        r_side_data <= 1'b0;
        r_last_data <= 1'b0;
        r_is_wr     <= 1'b0;
        r_err       <= 1'b0;
        r_wait_cnt  <= 8'd0;
      end
      if (w_grant_d) begin
        r_addr      <= dmmaddr;
        r_wdata     <= dmmstore;
        r_side_data <= 1'b1;
        r_last_data <= 1'b1;
        r_is_wr     <= dmmWen;
        r_err       <= 1'b0;
        r_wait_cnt  <= 8'd0;
      end
      if (w_in_acc && ram_busy) r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_abort) r_err <= 1'b1;
      // A completed write leaves the load register untouched.
      if (w_finish) begin
        if (!r_side_data)  r_imemload <= ram_rdata;
        else if (!r_is_wr) r_dmmload  <= ram_rdata;
      end
    end
  end

  assign ram_ren   = (r_state == S_IACC) || ((r_state == S_DACC) && !r_is_wr);
  assign ram_wen   = (r_state == S_DACC) && r_is_wr;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign i_ready   = (r_state == S_DONE) && !r_side_data;
  assign d_ready   = (r_state == S_DONE) && r_side_data;
  assign bus_err   = (r_state == S_DONE) && r_err;
  assign imemload  = r_imemload;
  assign dmmload   = r_dmmload;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter using directed access vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        tb_clk = 1'b0;
  logic        nRST;
  logic        imemRen;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        i_ready;
  logic        dmmRen;
  logic        dmmWen;
  logic [31:0] dmmaddr;
  logic [31:0] dmmstore;
  logic [31:0] dmmload;
  logic        d_ready;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_busy;
  logic        bus_err;

  typedef struct {
    logic        side;
    logic [31:0] load;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   cyc      = 0;
  int   last_cyc = -1;
  logic tie_mode = 1'b0;

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc++;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .CLK(tb_clk), .nRST(nRST),
    .imemRen(imemRen), .imemaddr(imemaddr), .imemload(imemload), .i_ready(i_ready),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .dmmload(dmmload), .d_ready(d_ready),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy), .bus_err(bus_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge tb_clk) begin
    if (nRST && (i_ready || d_ready)) begin
      check("ready_exclusive", 64'(i_ready & d_ready), 64'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_ready: got i=%0b d=%0b, expected no pulse", i_ready, d_ready);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_side", 64'(d_ready), 64'(e.side));
        check("load_value", 64'(e.side ? dmmload : imemload), 64'(e.load));
        check("bus_err", 64'(bus_err), 64'(e.err));
      end
      if (tie_mode && last_cyc >= 0) check("tie_gap", 64'(cyc - last_cyc), 64'd3);
      last_cyc = tie_mode ? cyc : -1;
    end
  end

  task automatic run_single(
    input logic ri, input logic rd, input logic wd,
    input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdat,
    input int busy_n, input int ncyc,
    input logic exp_side, input logic exp_ren, input logic exp_wen,
    input logic [31:0] exp_load, input logic exp_err);
    exp_t e;
    e.side = exp_side; e.load = exp_load; e.err = exp_err;
    sb.push_back(e);
    imemRen   = ri;
    dmmRen    = rd;
    dmmWen    = wd;
    imemaddr  = addr;
    dmmaddr   = ri ? ~addr : addr;
    dmmstore  = wdat;
    ram_rdata = rdat;
    ram_busy  = (busy_n > 0);
    tick(1);
    imemRen = 1'b0;
    dmmRen  = 1'b0;
    dmmWen  = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      check("ram_ren", 64'(ram_ren), 64'(exp_ren));
      check("ram_wen", 64'(ram_wen), 64'(exp_wen));
      check("ram_addr", 64'(ram_addr), 64'(addr));
      if (exp_wen) check("ram_wdata", 64'(ram_wdata), 64'(wdat));
      ram_busy = (k < busy_n);
      tick(1);
    end
    check("strobes_done", 64'({ram_ren, ram_wen}), 64'd0);
    ram_busy = 1'b0;
    tick(1);
  endtask

  initial begin
    exp_t e;
    nRST = 1'b0; imemRen = 1'b0; imemaddr = '0; dmmRen = 1'b0; dmmWen = 1'b0;
    dmmaddr = '0; dmmstore = '0; ram_rdata = '0; ram_busy = 1'b0;
    tick(2);
    check("reset_outputs", 64'({imemload, dmmload} | 64'({i_ready, d_ready, ram_ren, ram_wen, bus_err})), 64'd0);
    check("reset_bus", 64'({ram_addr, ram_wdata}), 64'd0);
    nRST = 1'b1;
    tick(1);

    // Fetch, then data read, store, and write-wins-over-read.
    run_single(1, 0, 0, 32'h1234_1234, 32'h0, 32'h00A0_0093, 0, 1, 0, 1, 0, 32'h00A0_0093, 0);
    run_single(0, 1, 0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 2, 3, 1, 1, 0, 32'hCAFE_F00D, 0);
    run_single(0, 0, 1, 32'h0101_0101, 32'hDACB_DACB, 32'hBAD0_BAD0, 3, 4, 1, 0, 1, 32'hCAFE_F00D, 0);
    run_single(0, 1, 1, 32'h0001_0001, 32'h1357_2468, 32'hBAD0_BAD0, 0, 1, 1, 0, 1, 32'hCAFE_F00D, 0);

    // Continuous tie after a data grant: I, D, I, D every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      e.side = k[0]; e.load = 32'h600D_F00D; e.err = 1'b0;
      sb.push_back(e);
    end
    tie_mode  = 1'b1;
    imemRen   = 1'b1; dmmRen = 1'b1; imemaddr = 32'h100; dmmaddr = 32'h200;
    ram_rdata = 32'h600D_F00D; ram_busy = 1'b0;
    tick(10);
    imemRen = 1'b0; dmmRen = 1'b0;
    tick(3);
    tie_mode = 1'b0;

    // Timeout: busy never drops; abort after 15 busy edges.
    run_single(0, 1, 0, 32'h0000_0080, 32'h0, 32'hDEAD_DEAD, 1000, 15, 1, 1, 0, 32'h600D_F00D, 1);

    // Reset in the middle of a data access.
    dmmRen = 1'b1; dmmaddr = 32'h44; ram_busy = 1'b1;
    tick(1);
    dmmRen = 1'b0;
    tick(2);
    check("mid_acc_ren", 64'(ram_ren), 64'd1);
    nRST = 1'b0;
    #1;
    check("midreset_outputs", 64'({imemload, dmmload} | 64'({i_ready, d_ready, ram_ren, ram_wen, bus_err})), 64'd0);
    check("midreset_addr", 64'(ram_addr), 64'd0);
    ram_busy = 1'b0;
    tick(2);
    nRST = 1'b1;
    tick(1);
    run_single(1, 1, 0, 32'h0000_0100, 32'h0, 32'h89AB_CDEF, 0, 1, 0, 1, 0, 32'h89AB_CDEF, 0);

    tick(3);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
